// File: rtl/j1_uart.sv
`timescale 1ns/1ps
// j1_uart -- 8N1 UART peripheral on the J1 data bus.
//   Four word registers at BASE_ADR..BASE_ADR+3:
//     0 DATA   W: push TX byte, R: pop RX byte ({8'h0,byte}, 0 when empty)
//     1 STATUS [0] rx_valid [1] tx_full [2] tx_idle [3] rx_ovr [4] tx_ovr [5] frame_err
//              ([5:3] sticky, write-1-to-clear)
//     2 DIV    bit period = DIV+1 clocks, minimum 3, latched at each frame start
//     3 CTRL   [0] rx_irq_en [1] tx_irq_en
//   Ports:
//     clk, reset_n          clock, asynchronous active-low reset
//     dbus_adr/re/we/dat_i  core bus strobes (single cycle, no stall)
//     dbus_dat_o            registered read data, 0 when not selected
//     uart_rxd / uart_txd   serial line in (asynchronous) / out
//     irq                   registered level interrupt
module j1_uart #(
  parameter logic [15:0] BASE_ADR    = 16'h3FF8,
  parameter int          TX_DEPTH    = 4,
  parameter int          RX_DEPTH    = 4,
  parameter logic [15:0] DEFAULT_DIV = 16'd433
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] dbus_adr,
  input  logic        dbus_re,
  input  logic        dbus_we,
  input  logic [15:0] dbus_dat_i,
  output logic [15:0] dbus_dat_o,
  input  logic        uart_rxd,
  output logic        uart_txd,
  output logic        irq
);
  localparam int TXW = $clog2(TX_DEPTH);
  localparam int RXW = $clog2(RX_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

  // Bus decode; a write beats a simultaneous read
  logic       sel, wr_en, rd_en;
  logic [1:0] ra;
  assign sel   = (dbus_adr[15:2] == BASE_ADR[15:2]);
  assign ra    = dbus_adr[1:0];
  assign wr_en = sel & dbus_we;
  assign rd_en = sel & dbus_re & ~dbus_we;

  logic [15:0] div_q, dat_o_q;
  logic [1:0]  ctrl_q;
  logic        rx_ovr_q, tx_ovr_q, ferr_q, irq_q;

  // TX FIFO
  logic [7:0]   tx_mem [TX_DEPTH];
  logic [TXW:0] tx_wp_q, tx_rp_q;
  logic         tx_empty, tx_full, tx_push, tx_pop, tx_ovr_set;
  assign tx_empty   = (tx_wp_q == tx_rp_q);
  assign tx_full    = (tx_wp_q[TXW] != tx_rp_q[TXW]) && (tx_wp_q[TXW-1:0] == tx_rp_q[TXW-1:0]);
  assign tx_push    = wr_en && (ra == 2'd0) && !tx_full;
  assign tx_ovr_set = wr_en && (ra == 2'd0) && tx_full;

  // RX FIFO; a full FIFO still accepts a push when a pop happens on the same edge
  logic [7:0]   rx_mem [RX_DEPTH];
  logic [RXW:0] rx_wp_q, rx_rp_q;
  logic         rx_empty, rx_full, rx_pop, rx_push_req, rx_push, rx_ovr_set, ferr_set;
  assign rx_empty   = (rx_wp_q == rx_rp_q);
  assign rx_full    = (rx_wp_q[RXW] != rx_rp_q[RXW]) && (rx_wp_q[RXW-1:0] == rx_rp_q[RXW-1:0]);
  assign rx_pop     = rd_en && (ra == 2'd0) && !rx_empty;
  assign rx_push    = rx_push_req && (!rx_full || rx_pop);
  assign rx_ovr_set = rx_push_req && rx_full && !rx_pop;

  // TX state
  state_e      tx_st_q, tx_st_d;
  logic [15:0] tx_cnt_q, tx_cnt_d, tx_div_q, tx_div_d;
  logic [2:0]  tx_bit_q, tx_bit_d;
  logic [7:0]  tx_sh_q, tx_sh_d;
  logic        txd_q, txd_d, tx_load, tx_end, tx_idle;
  assign tx_end  = (tx_cnt_q == tx_div_q);
  assign tx_idle = tx_empty && (tx_st_q == S_IDLE);

  always_comb begin
    tx_st_d  = tx_st_q;
    tx_cnt_d = tx_cnt_q + 16'd1;
    tx_div_d = tx_div_q;
    tx_bit_d = tx_bit_q;
    tx_sh_d  = tx_sh_q;
    tx_load  = 1'b0;
    tx_pop   = 1'b0;
    txd_d    = 1'b1;
    case (tx_st_q)
      S_IDLE: begin
        tx_cnt_d = '0;
        tx_load  = !tx_empty;
      end
      S_START: if (tx_end) begin
        tx_st_d  = S_DATA;
        tx_cnt_d = '0;
        tx_bit_d = '0;
      end
      S_DATA: if (tx_end) begin
        tx_cnt_d = '0;
        tx_sh_d  = {1'b0, tx_sh_q[7:1]};
        if (tx_bit_q == 3'd7) tx_st_d = S_STOP;
        else                  tx_bit_d = tx_bit_q + 3'd1;
      end
      S_STOP: if (tx_end) begin
        tx_cnt_d = '0;
        tx_st_d  = S_IDLE;
        tx_load  = !tx_empty;
      end
      default: tx_st_d = S_IDLE;
    endcase
    // Frame start: pop the FIFO into the shifter and latch the divisor
    if (tx_load) begin
      tx_st_d  = S_START;
      tx_cnt_d = '0;
      tx_div_d = div_q;
      tx_sh_d  = tx_mem[tx_rp_q[TXW-1:0]];
      tx_pop   = 1'b1;
    end
    // Line level is derived from next state so uart_txd is a clean flop output
    if (tx_st_d == S_START)     txd_d = 1'b0;
    else if (tx_st_d == S_DATA) txd_d = tx_sh_d[0];
  end

  // RX state
  state_e      rx_st_q, rx_st_d;
  logic [15:0] rx_cnt_q, rx_cnt_d, rx_div_q, rx_div_d;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic [7:0]  rx_sh_q, rx_sh_d;
  logic        rx_s1_q, rx_s2_q, rx_prev_q, rx_end;
  assign rx_end = (rx_cnt_q == rx_div_q);

  always_comb begin
    rx_st_d     = rx_st_q;
    rx_cnt_d    = rx_cnt_q + 16'd1;
    rx_div_d    = rx_div_q;
    rx_bit_d    = rx_bit_q;
    rx_sh_d     = rx_sh_q;
    rx_push_req = 1'b0;
    ferr_set    = 1'b0;
    case (rx_st_q)
      S_IDLE: begin
        rx_cnt_d = '0;
        if (rx_prev_q && !rx_s2_q) begin
          rx_st_d  = S_START;
          rx_div_d = div_q;
        end
      end
      // Half a bit after the edge: still low means a real start bit
      S_START: if (rx_cnt_q == {1'b0, rx_div_q[15:1]}) begin
        rx_cnt_d = '0;
        rx_bit_d = '0;
        rx_st_d  = rx_s2_q ? S_IDLE : S_DATA;
      end
      S_DATA: if (rx_end) begin
        rx_cnt_d = '0;
        rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
        if (rx_bit_q == 3'd7) rx_st_d = S_STOP;
        else                  rx_bit_d = rx_bit_q + 3'd1;
      end
      S_STOP: if (rx_end) begin
        rx_cnt_d    = '0;
        rx_st_d     = S_IDLE;
        rx_push_req = rx_s2_q;
        ferr_set    = !rx_s2_q;
      end
      default: rx_st_d = S_IDLE;
    endcase
  end

  // Register read mux
  logic [15:0] rdata;
  always_comb begin
    rdata = '0;
    case (ra)
      2'd0: if (!rx_empty) rdata = {8'h00, rx_mem[rx_rp_q[RXW-1:0]]};
      2'd1: rdata = {10'd0, ferr_q, tx_ovr_q, rx_ovr_q, tx_idle, tx_full, !rx_empty};
      2'd2: rdata = div_q;
      default: rdata = {14'd0, ctrl_q};
    endcase
  end

  logic wr_st;
  assign wr_st = wr_en && (ra == 2'd1);

  // Data storage, no reset
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp_q[TXW-1:0]] <= dbus_dat_i[7:0];
    if (rx_push) rx_mem[rx_wp_q[RXW-1:0]] <= rx_sh_q;
    tx_sh_q <= tx_sh_d;
    rx_sh_q <= rx_sh_d;
  end

  // Control state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_wp_q   <= '0;
      tx_rp_q   <= '0;
      rx_wp_q   <= '0;
      rx_rp_q   <= '0;
      tx_st_q   <= S_IDLE;
      tx_cnt_q  <= '0;
      tx_div_q  <= DEFAULT_DIV;
      tx_bit_q  <= '0;
      txd_q     <= 1'b1;
      rx_st_q   <= S_IDLE;
      rx_cnt_q  <= '0;
      rx_div_q  <= DEFAULT_DIV;
      rx_bit_q  <= '0;
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
      div_q     <= DEFAULT_DIV;
      ctrl_q    <= '0;
      rx_ovr_q  <= 1'b0;
      tx_ovr_q  <= 1'b0;
      ferr_q    <= 1'b0;
      dat_o_q   <= '0;
      irq_q     <= 1'b0;
    end else begin
      if (tx_push) tx_wp_q <= tx_wp_q + 1'b1;
      if (tx_pop)  tx_rp_q <= tx_rp_q + 1'b1;
      if (rx_push) rx_wp_q <= rx_wp_q + 1'b1;
      if (rx_pop)  rx_rp_q <= rx_rp_q + 1'b1;
      tx_st_q   <= tx_st_d;
      tx_cnt_q  <= tx_cnt_d;
      tx_div_q  <= tx_div_d;
      tx_bit_q  <= tx_bit_d;
      txd_q     <= txd_d;
      rx_st_q   <= rx_st_d;
      rx_cnt_q  <= rx_cnt_d;
      rx_div_q  <= rx_div_d;
      rx_bit_q  <= rx_bit_d;
      rx_s1_q   <= uart_rxd;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
      if (wr_en && (ra == 2'd2)) div_q  <= (dbus_dat_i < 16'd3) ? 16'd3 : dbus_dat_i;
      if (wr_en && (ra == 2'd3)) ctrl_q <= dbus_dat_i[1:0];
      // Set wins over a same-cycle write-1-to-clear
      rx_ovr_q <= (rx_ovr_q & ~(wr_st & dbus_dat_i[3])) | rx_ovr_set;
      tx_ovr_q <= (tx_ovr_q & ~(wr_st & dbus_dat_i[4])) | tx_ovr_set;
      ferr_q   <= (ferr_q   & ~(wr_st & dbus_dat_i[5])) | ferr_set;
      dat_o_q  <= rd_en ? rdata : 16'd0;
      irq_q    <= (ctrl_q[0] & !rx_empty) | (ctrl_q[1] & tx_idle);
    end
  end

  assign dbus_dat_o = dat_o_q;
  assign uart_txd   = txd_q;
  assign irq        = irq_q;
endmodule
